// File: rtl/led_fader_pwm.sv
// led_fader_pwm
//   Multi-channel LED brightness controller. Each channel holds a latched
//   target, a current level and a PWM shadow copy of that level. The level
//   moves in one of four modes: DIRECT (follow target every cycle), FADE
//   (step toward target once per ramp tick), BREATHE (bounce 0..MAX once
//   per ramp tick) and HOLD (frozen). A free-running PWM counter compares
//   against the shadow copy, so duty only changes on period boundaries.
//
// Ports
//   sys_clk  in   1      system clock, rising edge
//   rst_n    in   1      asynchronous active-low reset
//   target   in   CH*PW  per-channel target, channel i at [i*PW +: PW]
//   load     in   1      latch target into the per-channel tgt registers
//   mode     in   2      00 DIRECT, 01 FADE, 10 BREATHE, 11 HOLD
//   LED      out  CH     registered PWM outputs
//   at_max   out  CH     level[i] == MAX
//   at_min   out  CH     level[i] == 0
//   busy     out  1      mode is FADE and some level differs from its tgt
//
// Handshake: there is no valid/ready pair; load is a single-cycle strobe
// sampled on every rising edge, and mode is level-sensitive.
module led_fader_pwm #(
   parameter int CH   = 16,
   parameter int PW   = 8,
   parameter int DIV  = 500_000,
   parameter int STEP = 1
) (
   input  logic             sys_clk,
   input  logic             rst_n,
   input  logic [CH*PW-1:0] target,
   input  logic             load,
   input  logic [1:0]       mode,
   output logic [CH-1:0]    LED,
   output logic [CH-1:0]    at_max,
   output logic [CH-1:0]    at_min,
   output logic             busy
);

   localparam int MAX = (1 << PW) - 1;
   localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;

   localparam logic [PW-1:0] MAX_V  = PW'(MAX);
   localparam logic [PW-1:0] PEND_V = PW'(MAX - 1);
   localparam logic [PW-1:0] STEP_N = PW'(STEP);
   localparam logic [PW:0]   STEP_V = (PW+1)'(STEP);
   localparam logic [DW-1:0] DEND_V = DW'(DIV - 1);

   typedef enum logic [1:0] {
      MODE_DIRECT  = 2'b00,
      MODE_FADE    = 2'b01,
      MODE_BREATHE = 2'b10,
      MODE_HOLD    = 2'b11
   } mode_e;

   mode_e mode_s;
   assign mode_s = mode_e'(mode);

   logic [PW-1:0]         pcnt_q, pcnt_d;
   logic [DW-1:0]         dcnt_q, dcnt_d;
   logic [CH-1:0][PW-1:0] tgt_q, tgt_d;
   logic [CH-1:0][PW-1:0] level_q, level_d;
   logic [CH-1:0][PW-1:0] shadow_q, shadow_d;
   logic [CH-1:0]         dir_q, dir_d;      // 1 = up, 0 = down
   logic [CH-1:0]         led_q, led_d;
   logic                  breathe_q, breathe_d;

   logic                  tick;
   logic                  period_end;
   logic [CH-1:0][PW:0]   up_sum;            // level + STEP, one guard bit
   logic [CH-1:0][PW:0]   dn_floor;          // tgt + STEP, one guard bit
   logic [CH-1:0][PW-1:0] dn_val;            // level - STEP, used only when no underflow
   logic [CH-1:0]         eff_dir;

   assign tick       = (dcnt_q == DEND_V);
   assign period_end = (pcnt_q == PEND_V);

   // Per-channel arithmetic. The guard bit keeps level+STEP from wrapping,
   // so clamping against tgt or MAX is a plain compare.
   // eff_dir picks the breathing direction from the current level on the
   // first cycle BREATHE is seen, otherwise keeps the stored direction.
   always_comb begin : arith
      up_sum   = '0;
      dn_floor = '0;
      dn_val   = '0;
      eff_dir  = '0;
      for (int i = 0; i < CH; i++) begin
         up_sum[i]   = {1'b0, level_q[i]} + STEP_V;
         dn_floor[i] = {1'b0, tgt_q[i]} + STEP_V;
         dn_val[i]   = level_q[i] - STEP_N;
         eff_dir[i]  = breathe_q ? dir_q[i] : (level_q[i] != MAX_V);
      end
   end

   always_comb begin : next_state
      pcnt_d    = period_end ? '0 : pcnt_q + PW'(1);
      dcnt_d    = tick ? '0 : dcnt_q + DW'(1);
      tgt_d     = load ? target : tgt_q;
      level_d   = level_q;
      shadow_d  = shadow_q;
      dir_d     = dir_q;
      led_d     = '0;
      breathe_d = (mode_s == MODE_BREATHE);

      for (int i = 0; i < CH; i++) begin
         // Shadow copies the level only at the last count of a period, so a
         // duty change never cuts or stretches a pulse mid-period.
         if (period_end) begin
            shadow_d[i] = level_q[i];
         end
         led_d[i] = (pcnt_q < shadow_q[i]);

         case (mode_s)
            MODE_DIRECT: begin
               level_d[i] = tgt_q[i];
            end
            MODE_FADE: begin
               if (tick) begin
                  if (level_q[i] < tgt_q[i]) begin
                     level_d[i] = (up_sum[i] > {1'b0, tgt_q[i]}) ? tgt_q[i]
                                                                : up_sum[i][PW-1:0];
                  end else if (level_q[i] > tgt_q[i]) begin
                     // level - STEP stays at or above tgt only if level >= tgt + STEP.
                     level_d[i] = ({1'b0, level_q[i]} >= dn_floor[i]) ? dn_val[i]
                                                                     : tgt_q[i];
                  end
               end
            end
            MODE_BREATHE: begin
               dir_d[i] = eff_dir[i];
               if (tick) begin
                  if (eff_dir[i]) begin
                     if (up_sum[i] >= {1'b0, MAX_V}) begin
                        level_d[i] = MAX_V;
                        dir_d[i]   = 1'b0;
                     end else begin
                        level_d[i] = up_sum[i][PW-1:0];
                     end
                  end else begin
                     if (level_q[i] <= STEP_N) begin
                        level_d[i] = '0;
                        dir_d[i]   = 1'b1;
                     end else begin
                        level_d[i] = dn_val[i];
                     end
                  end
               end
            end
            default: begin
               // HOLD: level frozen, tgt still loadable above.
            end
         endcase
      end
   end

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         pcnt_q    <= '0;
         dcnt_q    <= '0;
         tgt_q     <= '0;
         level_q   <= '0;
         shadow_q  <= '0;
         dir_q     <= '1;
         led_q     <= '0;
         breathe_q <= 1'b0;
      end else begin
         pcnt_q    <= pcnt_d;
         dcnt_q    <= dcnt_d;
         tgt_q     <= tgt_d;
         level_q   <= level_d;
         shadow_q  <= shadow_d;
         dir_q     <= dir_d;
         led_q     <= led_d;
         breathe_q <= breathe_d;
      end
   end

   assign LED = led_q;

   always_comb begin : flags
      at_max = '0;
      at_min = '0;
      for (int i = 0; i < CH; i++) begin
         at_max[i] = (level_q[i] == MAX_V);
         at_min[i] = (level_q[i] == '0);
      end
   end

   assign busy = (mode_s == MODE_FADE) && (level_q != tgt_q);

endmodule

// File: tb/tb_led_fader_pwm.sv
module tb_led_fader_pwm;

   localparam int CH  = 2;
   localparam int PW  = 4;
   localparam int DIV = 4;

   logic          sys_clk = 1'b0;
   logic          rst_n   = 1'b0;

   // STEP=1 instance
   logic [CH*PW-1:0] target = '0;
   logic             load   = 1'b0;
   logic [1:0]       mode   = 2'b00;
   logic [CH-1:0]    led, at_max, at_min;
   logic             busy;

   // STEP=4 instance
   logic [CH*PW-1:0] t4_target = '0;
   logic             t4_load   = 1'b0;
   logic [1:0]       t4_mode   = 2'b00;
   logic [CH-1:0]    t4_led, t4_at_max, t4_at_min;
   logic             t4_busy;

   int passed = 0;
   int failed = 0;
   int total  = 0;

   // Bench model of the ramp timebase: tick fires on the edge where this is 3.
   logic [1:0] m_dcnt;

   always #5 sys_clk = ~sys_clk;

   always @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) m_dcnt <= 2'd0;
      else        m_dcnt <= (m_dcnt == 2'd3) ? 2'd0 : m_dcnt + 2'd1;
   end

   led_fader_pwm #(.CH(CH), .PW(PW), .DIV(DIV), .STEP(1)) dut (
      .sys_clk (sys_clk),
      .rst_n   (rst_n),
      .target  (target),
      .load    (load),
      .mode    (mode),
      .LED     (led),
      .at_max  (at_max),
      .at_min  (at_min),
      .busy    (busy)
   );

   led_fader_pwm #(.CH(CH), .PW(PW), .DIV(DIV), .STEP(4)) dut4 (
      .sys_clk (sys_clk),
      .rst_n   (rst_n),
      .target  (t4_target),
      .load    (t4_load),
      .mode    (t4_mode),
      .LED     (t4_led),
      .at_max  (t4_at_max),
      .at_min  (t4_at_min),
      .busy    (t4_busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total = total + 1;
      assert (obs === exp) passed = passed + 1;
      else begin
         failed = failed + 1;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge sys_clk);
   endtask

   // Called at a negedge; returns at the negedge just after the next tick edge.
   task automatic next_tick;
      while (m_dcnt != 2'd3) @(negedge sys_clk);
      @(negedge sys_clk);
   endtask

   task automatic count_high(output int c0, output int c1);
      c0 = 0;
      c1 = 0;
      for (int k = 0; k < 15; k++) begin
         @(negedge sys_clk);
         c0 += int'(led[0]);
         c1 += int'(led[1]);
      end
   endtask

   initial begin
      int c0, c1;
      int exp_lvl;

      // ---- 1a: reset values ----
      step(3);
      check("rst_led",    led,    2'b00);
      check("rst_at_min", at_min, 2'b11);
      check("rst_at_max", at_max, 2'b00);
      check("rst_busy",   busy,   1'b0);
      rst_n = 1'b1;
      step(1);
      check("post_rst_led",    led,    2'b00);
      check("post_rst_at_min", at_min, 2'b11);

      // ---- 2: DIRECT PWM duty ----
      mode = 2'b00; target = {4'd15, 4'd5}; load = 1'b1;
      step(1);
      load = 1'b0;
      step(40);
      count_high(c0, c1);
      check("direct_duty5",  c0, 5);
      check("direct_duty15", c1, 15);
      check("direct_at_max", at_max, 2'b10);
      check("direct_at_min", at_min, 2'b00);
      target = 8'h00; load = 1'b1;
      step(1);
      load = 1'b0;
      step(40);
      count_high(c0, c1);
      check("direct_duty0_ch0", c0, 0);
      check("direct_duty0_ch1", c1, 0);
      check("direct_zero_at_min", at_min, 2'b11);

      // ---- 3: FADE 0 -> 15 ----
      mode = 2'b01; target = {4'd0, 4'd15}; load = 1'b1;
      step(1);
      load = 1'b0;
      check("fade_busy_start", busy, 1'b1);
      for (int t = 1; t <= 15; t++) begin
         next_tick;
         check("fade_level", dut.level_q[0], t);
         check("fade_busy",  busy, (t < 15) ? 1 : 0);
      end
      check("fade_at_max", at_max, 2'b01);
      step(8);
      check("fade_no_overshoot", dut.level_q[0], 15);

      // ---- 6: load coincident with tick ----
      mode = 2'b00; target = 8'h03; load = 1'b1;
      step(1);
      load = 1'b0;
      step(1);
      check("coin_setup_lvl", dut.level_q[0], 3);
      mode = 2'b11; target = 8'h0A; load = 1'b1;
      step(1);
      load = 1'b0;
      step(5);
      check("hold_frozen", dut.level_q[0], 3);
      check("hold_busy",   busy, 1'b0);
      while (m_dcnt != 2'd3) step(1);
      mode = 2'b01; target = 8'h00; load = 1'b1;
      step(1);
      load = 1'b0;
      check("coin_old_tgt", dut.level_q[0], 4);
      check("coin_busy",    busy, 1'b1);
      next_tick;
      check("coin_new_tgt", dut.level_q[0], 3);

      // ---- 5: BREATHE 0 -> 15 -> 0 -> 1 ----
      mode = 2'b00; target = 8'h00; load = 1'b1;
      step(1);
      load = 1'b0;
      step(1);
      while (m_dcnt != 2'd0) step(1);
      mode = 2'b10;
      for (int t = 1; t <= 31; t++) begin
         next_tick;
         exp_lvl = (t <= 15) ? t : ((t <= 30) ? 30 - t : t - 30);
         check("breathe_lvl0", dut.level_q[0], exp_lvl);
         check("breathe_lvl1", dut.level_q[1], exp_lvl);
         if (t == 15) check("breathe_at_max", at_max, 2'b11);
         if (t == 30) check("breathe_at_min", at_min, 2'b11);
      end

      // ---- 4: FADE with STEP=4 ----
      t4_mode = 2'b01; t4_target = 8'h06; t4_load = 1'b1;
      step(1);
      t4_load = 1'b0;
      next_tick;
      check("step4_up1", dut4.level_q[0], 4);
      next_tick;
      check("step4_clamp", dut4.level_q[0], 6);
      next_tick;
      check("step4_stay", dut4.level_q[0], 6);
      t4_target = 8'h01; t4_load = 1'b1;
      step(1);
      t4_load = 1'b0;
      next_tick;
      check("step4_dn1", dut4.level_q[0], 2);
      next_tick;
      check("step4_floor", dut4.level_q[0], 1);
      check("step4_busy", t4_busy, 1'b0);

      // ---- 1b: async reset mid-fade ----
      mode = 2'b00; target = 8'h00; load = 1'b1;
      step(1);
      load = 1'b0;
      step(1);
      mode = 2'b01; target = 8'h0F; load = 1'b1;
      step(1);
      load = 1'b0;
      repeat (7) next_tick;
      check("midfade_lvl", dut.level_q[0], 7);
      rst_n = 1'b0;
      #1;
      check("async_led",     led, 2'b00);
      check("async_level",   dut.level_q[0], 0);
      check("async_at_min",  at_min, 2'b11);
      check("async_busy",    busy, 1'b0);
      check("async_level4",  dut4.level_q[0], 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
